ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with prefetch queue and branch redirect
//
// Fetches instruction words from memory into a small FIFO ahead of the IR.
// A branch flushes the FIFO and restarts fetch at the target. A request that
// is already on the bus when a branch arrives is still completed, but its
// data is thrown away.
//
// Ports:
//   clk, rst_f           clock, asynchronous active-low reset
//   fetch_en             allow new memory requests
//   im_req, im_addr      memory read request and word address
//   im_ack, im_data      memory completion and returned word
//   ir_valid, ir_instr,  queue head presence, instruction, address
//   ir_pc
//   ir_load              pop the queue head
//   br_take, br_addr     redirect fetch to br_addr and flush the queue
//   q_count              queue occupancy (0..DEPTH)
module ifetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          fetch_en,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_ack,
  input  logic [DW-1:0] im_data,
  output logic          ir_valid,
  output logic [DW-1:0] ir_instr,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_load,
  input  logic          br_take,
  input  logic [AW-1:0] br_addr,
  output logic [3:0]    q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [3:0] FULL = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] fpc, fpc_nx;
  logic [AW-1:0] drop_addr;
  logic [DW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [3:0]    count, count_nx;
  logic          pop, push;

  always_comb begin
    // A branch overrides both queue operations in the same cycle.
    pop      = ir_load && (count != 4'd0) && !br_take;
    push     = (state == REQ) && im_ack && !br_take;
    count_nx = br_take ? 4'd0 : (count + {3'b000, push} - {3'b000, pop});
    state_nx = state;
    fpc_nx   = br_take ? br_addr : fpc;
    case (state)
      IDLE: begin
        if (fetch_en && (count_nx < FULL)) state_nx = REQ;
      end
      REQ: begin
        if (im_ack) begin
          if (!br_take) fpc_nx = fpc + AW'(1);
          state_nx = (fetch_en && (count_nx < FULL)) ? REQ : IDLE;
        end else if (br_take) begin
          state_nx = DROP;
        end
      end
      DROP: begin
        if (im_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= IDLE;
      fpc       <= '0;
      drop_addr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= 4'd0;
    end else begin
      state <= state_nx;
      fpc   <= fpc_nx;
      count <= count_nx;
      // The abandoned request keeps its address on the bus while fpc
      // already points at the branch target.
      if ((state == REQ) && br_take && !im_ack) drop_addr <= fpc;
      if (br_take) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // Payload storage needs no reset: it is only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= im_data;
      q_pc[wr_ptr]    <= fpc;
    end
  end

  assign im_req   = (state != IDLE);
  assign im_addr  = (state == DROP) ? drop_addr : fpc;
  assign ir_valid = (count != 4'd0);
  assign ir_instr = ir_valid ? q_instr[rd_ptr] : '0;
  assign ir_pc    = ir_valid ? q_pc[rd_ptr] : '0;
  assign q_count  = count;

endmodule
